// File: rtl/reg_status_table_mp_if.sv
// Issue/commit/checkpoint bus of the register status table.
// The scheduler side drives sources, writes, commits and checkpoint control; the table returns operand tags.
interface reg_status_table_mp_if #(
    parameter int NUM_REGS = 32,
    parameter int ROB_W    = 4,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int NUM_CKPT = 4
) ();
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic                      flush;
    logic [ISSUE_W*RW-1:0]     rs1;
    logic [ISSUE_W*RW-1:0]     rs2;
    logic [ISSUE_W-1:0]        issue_writes;
    logic [ISSUE_W*RW-1:0]     issue_dest;
    logic [ISSUE_W*ROB_W-1:0]  issue_ROB;
    logic [COMMIT_W-1:0]       commit_valid;
    logic [COMMIT_W-1:0]       RegWrite;
    logic [COMMIT_W*RW-1:0]    commit_dest;
    logic [COMMIT_W*ROB_W-1:0] commit_ROB;
    logic                      ckpt_save;
    logic                      ckpt_restore;
    logic [CW-1:0]             ckpt_sel;
    logic [ISSUE_W*ROB_W-1:0]  Q_j;
    logic [ISSUE_W*ROB_W-1:0]  Q_k;
    logic [ISSUE_W-1:0]        busy_j;
    logic [ISSUE_W-1:0]        busy_k;

    modport master (
        output flush, rs1, rs2, issue_writes, issue_dest, issue_ROB,
               commit_valid, RegWrite, commit_dest, commit_ROB,
               ckpt_save, ckpt_restore, ckpt_sel,
        input  Q_j, Q_k, busy_j, busy_k
    );

    modport slave (
        input  flush, rs1, rs2, issue_writes, issue_dest, issue_ROB,
               commit_valid, RegWrite, commit_dest, commit_ROB,
               ckpt_save, ckpt_restore, ckpt_sel,
        output Q_j, Q_k, busy_j, busy_k
    );
endinterface

// File: rtl/reg_status_table_mp.sv
// Multi-issue/multi-commit register status table with branch checkpoints.
// Each architectural register records whether a write is in flight and the ROB tag that will produce it.
module reg_status_table_mp #(
    parameter int NUM_REGS = 32,
    parameter int ROB_W    = 4,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int NUM_CKPT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_status_table_mp_if.slave   bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] rob;
    } entry_t;

    entry_t tbl     [NUM_REGS];
    entry_t tbl_nx  [NUM_REGS];
    entry_t ckpt    [NUM_CKPT][NUM_REGS];
    entry_t ckpt_nx [NUM_CKPT][NUM_REGS];

    logic sel_ok, do_restore, do_save;

    // A commit clears an entry only while it still holds the committing tag.
    function automatic entry_t apply_clears(
        input entry_t                    e,
        input logic [RW-1:0]             r,
        input logic [COMMIT_W-1:0]       en,
        input logic [COMMIT_W*RW-1:0]    dest,
        input logic [COMMIT_W*ROB_W-1:0] tag
    );
        entry_t res;
        res = e;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (en[c] && dest[c*RW +: RW] == r && e.busy && e.rob == tag[c*ROB_W +: ROB_W])
                res = '0;
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        for (int r = 0; r < NUM_REGS; r++) begin
            tbl_nx[r] = '0;
            for (int s = 0; s < NUM_CKPT; s++) ckpt_nx[s][r] = '0;
        end
        sel_ok     = {1'b0, bus.ckpt_sel} < (CW+1)'(NUM_CKPT);
        do_restore = bus.ckpt_restore && sel_ok;
        do_save    = bus.ckpt_save && !bus.ckpt_restore && sel_ok;

        // Register 0 is skipped so it stays {0,0} forever.
        for (int r = 1; r < NUM_REGS; r++) begin
            entry_t t;
            for (int s = 0; s < NUM_CKPT; s++)
                ckpt_nx[s][r] = apply_clears(ckpt[s][r], RW'(r), bus.commit_valid & bus.RegWrite,
                                             bus.commit_dest, bus.commit_ROB);
            t = apply_clears(tbl[r], RW'(r), bus.commit_valid & bus.RegWrite,
                             bus.commit_dest, bus.commit_ROB);
            for (int k = 0; k < ISSUE_W; k++) begin
                if (bus.issue_writes[k] && bus.issue_dest[k*RW +: RW] == RW'(r)) begin
                    t.busy = 1'b1;
                    t.rob  = bus.issue_ROB[k*ROB_W +: ROB_W];
                end
            end
            tbl_nx[r] = do_restore ? ckpt_nx[bus.ckpt_sel][r] : t;
            if (do_save) ckpt_nx[bus.ckpt_sel][r] = t;
        end
    end

    // NOTE: the table and checkpoints are architectural state, so every entry is reset, not just a valid bit.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tbl[r] <= '0;
                for (int s = 0; s < NUM_CKPT; s++) ckpt[s][r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tbl[r] <= tbl_nx[r];
                for (int s = 0; s < NUM_CKPT; s++) ckpt[s][r] <= ckpt_nx[s][r];
            end
        end
    end

    // Operand lookup: the youngest older slot writing the source this cycle overrides the table.
    always_comb begin
        logic [RW-1:0] src;
        entry_t        e;
        src        = '0;
        e          = '0;
        bus.busy_j = '0;
        bus.busy_k = '0;
        bus.Q_j    = '0;
        bus.Q_k    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int op = 0; op < 2; op++) begin
                src = (op == 0) ? bus.rs1[i*RW +: RW] : bus.rs2[i*RW +: RW];
                e   = tbl[src];
                for (int k = 0; k < i; k++) begin
                    if (bus.issue_writes[k] && bus.issue_dest[k*RW +: RW] == src) begin
                        e.busy = 1'b1;
                        e.rob  = bus.issue_ROB[k*ROB_W +: ROB_W];
                    end
                end
                if (src == '0 || !e.busy) e = '0;
                if (op == 0) begin
                    bus.busy_j[i]              = e.busy;
                    bus.Q_j[i*ROB_W +: ROB_W]  = e.rob;
                end else begin
                    bus.busy_k[i]              = e.busy;
                    bus.Q_k[i*ROB_W +: ROB_W]  = e.rob;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_status_table_mp.sv
// Directed bench for reg_status_table_mp: bypass, issue/commit races, checkpoints, flush and reset.
module tb_reg_status_table_mp;
    localparam int RW = 5;
    localparam int RB = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_status_table_mp_if #(.NUM_REGS(32), .ROB_W(4), .ISSUE_W(2), .COMMIT_W(2), .NUM_CKPT(4)) bus ();

    reg_status_table_mp #(.NUM_REGS(32), .ROB_W(4), .ISSUE_W(2), .COMMIT_W(2), .NUM_CKPT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.rs1          = '0;
        bus.rs2          = '0;
        bus.issue_writes = '0;
        bus.issue_dest   = '0;
        bus.issue_ROB    = '0;
        bus.commit_valid = '0;
        bus.RegWrite     = '0;
        bus.commit_dest  = '0;
        bus.commit_ROB   = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_restore = 1'b0;
        bus.ckpt_sel     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input int slot, input int dest, input int rob);
        bus.issue_writes[slot]          = 1'b1;
        bus.issue_dest[slot*RW +: RW]   = RW'(dest);
        bus.issue_ROB[slot*RB +: RB]    = RB'(rob);
    endtask

    task automatic commit(input int port, input int dest, input int rob);
        bus.commit_valid[port]          = 1'b1;
        bus.RegWrite[port]              = 1'b1;
        bus.commit_dest[port*RW +: RW]  = RW'(dest);
        bus.commit_ROB[port*RB +: RB]   = RB'(rob);
    endtask

    // Table entry as seen through slot 0 rs1 (slot 0 never bypasses).
    task automatic peek(input string tag, input int r, input logic b, input int q);
        bus.rs1[0 +: RW] = RW'(r);
        #1;
        check({tag, ".busy"}, 32'(bus.busy_j[0]), 32'(b));
        check({tag, ".q"}, 32'(bus.Q_j[0 +: RB]), 32'(q));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        issue(0, 5, 9);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        // Reset state across both slots and both operands.
        bus.rs1 = {RW'(5), RW'(5)};
        bus.rs2 = {RW'(31), RW'(1)};
        #1;
        check("rst.busy_j", 32'(bus.busy_j), 0);
        check("rst.busy_k", 32'(bus.busy_k), 0);
        check("rst.q_j", 32'(bus.Q_j), 0);
        check("rst.q_k", 32'(bus.Q_k), 0);

        // Test 1: issue r5 tag 3.
        idle();
        issue(0, 5, 3);
        tick();
        peek("t1.r5", 5, 1'b1, 3);

        // Test 2: same-cycle bypass from slot 0 to slot 1; slot 0 itself reads the table.
        idle();
        issue(0, 7, 2);
        bus.rs1 = {RW'(7), RW'(7)};
        bus.rs2 = {RW'(0), RW'(5)};
        #1;
        check("t2.s1_busy_j", 32'(bus.busy_j[1]), 1);
        check("t2.s1_q_j", 32'(bus.Q_j[RB +: RB]), 2);
        check("t2.s1_busy_k_r0", 32'(bus.busy_k[1]), 0);
        check("t2.s1_q_k_r0", 32'(bus.Q_k[RB +: RB]), 0);
        check("t2.s0_busy_j", 32'(bus.busy_j[0]), 0);
        check("t2.s0_busy_k_r5", 32'(bus.busy_k[0]), 1);
        check("t2.s0_q_k_r5", 32'(bus.Q_k[0 +: RB]), 3);
        tick();
        peek("t2.r7", 7, 1'b1, 2);

        // Test 3: stale-tag commit ignored, matching-tag commit clears.
        issue(0, 5, 6);
        tick();
        commit(0, 5, 3);
        tick();
        peek("t3.r5_stale", 5, 1'b1, 6);
        commit(1, 5, 6);
        tick();
        peek("t3.r5_clear", 5, 1'b0, 0);

        // Commit without RegWrite, or without valid, has no effect.
        issue(0, 11, 1);
        tick();
        commit(0, 11, 1);
        bus.RegWrite = '0;
        tick();
        commit(1, 11, 1);
        bus.commit_valid = '0;
        tick();
        peek("t3.r11_nowr", 11, 1'b1, 1);

        // Test 4: same-cycle issue beats matching commit clear.
        issue(0, 9, 4);
        tick();
        commit(0, 9, 4);
        issue(1, 9, 8);
        tick();
        peek("t4.r9", 9, 1'b1, 8);

        // Test 5: checkpoint save/restore with a commit clear applied to the checkpoint.
        issue(0, 4, 1);
        tick();
        bus.ckpt_save = 1'b1;
        bus.ckpt_sel  = 2'd2;
        tick();
        issue(0, 4, 5);
        issue(1, 6, 7);
        tick();
        commit(0, 4, 1);
        tick();
        peek("t5.r4_live", 4, 1'b1, 5);
        bus.ckpt_restore = 1'b1;
        bus.ckpt_sel     = 2'd2;
        tick();
        peek("t5.r4", 4, 1'b0, 0);
        peek("t5.r6", 6, 1'b0, 0);
        peek("t5.r9", 9, 1'b1, 8);
        peek("t5.r7", 7, 1'b1, 2);

        // Save captures next-state; restore discards same-cycle issues and applies same-cycle clears.
        issue(0, 12, 9);
        bus.ckpt_save = 1'b1;
        bus.ckpt_sel  = 2'd1;
        tick();
        issue(0, 12, 10);
        tick();
        peek("ck.r12_new", 12, 1'b1, 10);
        bus.ckpt_restore = 1'b1;
        bus.ckpt_sel     = 2'd1;
        issue(0, 13, 3);
        tick();
        peek("ck.r12_rest", 12, 1'b1, 9);
        peek("ck.r13_drop", 13, 1'b0, 0);
        issue(0, 12, 10);
        tick();
        bus.ckpt_restore = 1'b1;
        bus.ckpt_sel     = 2'd1;
        commit(0, 12, 9);
        tick();
        peek("ck.r12_clr", 12, 1'b0, 0);

        // Test 6: youngest slot wins, then flush with concurrent issue clears everything.
        issue(0, 10, 2);
        issue(1, 10, 3);
        tick();
        peek("t6.r10", 10, 1'b1, 3);
        bus.flush = 1'b1;
        issue(0, 14, 5);
        tick();
        peek("t6.r10_fl", 10, 1'b0, 0);
        peek("t6.r14_fl", 14, 1'b0, 0);
        peek("t6.r9_fl", 9, 1'b0, 0);
        bus.ckpt_restore = 1'b1;
        bus.ckpt_sel     = 2'd2;
        tick();
        peek("t6.ckpt_fl", 9, 1'b0, 0);

        // Reset mid-operation beats a concurrent issue.
        issue(0, 3, 7);
        tick();
        peek("rm.r3", 3, 1'b1, 7);
        reset = 1'b1;
        issue(0, 3, 8);
        tick();
        reset = 1'b0;
        peek("rm.r3_rst", 3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
